// File: rtl/sequence_round_controller_if.sv
// Handshake bundle between the round controller, the memory-game datapath
// and the top-level game controller.
//   master : game/datapath side, drives iniciar, jogada, igual and fim_c and
//            observes the controller's commands and status.
//   slave  : the round controller itself.
// Signals:
//   iniciar    start/restart a round (level)
//   jogada     player button level (edge-detected by the controller)
//   igual      datapath compare result
//   fim_c      position counter rco
//   zera_c     counter clear, active-low
//   conta_c    counter enable (ent/enp)
//   zera_r     clear player-input register
//   registra_r load player-input register
//   pronto     round finished
//   acertou    round finished, all correct
//   errou      round finished with mismatch or timeout
//   timeout    round ended by timeout
//   db_estado  current state code
interface sequence_round_controller_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fim_c;
  logic       zera_c;
  logic       conta_c;
  logic       zera_r;
  logic       registra_r;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    output iniciar, jogada, igual, fim_c,
    input  zera_c, conta_c, zera_r, registra_r,
    input  pronto, acertou, errou, timeout, db_estado
  );

  modport slave (
    input  iniciar, jogada, igual, fim_c,
    output zera_c, conta_c, zera_r, registra_r,
    output pronto, acertou, errou, timeout, db_estado
  );
endinterface

// File: rtl/sequence_round_controller.sv
// Moore FSM that sequences one play round of the memory game: clears the
// position counter and player register, waits for a player press, loads and
// compares the play, and steps the counter until its terminal count.
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high; returns the FSM to INICIAL
//   bus    sequence_round_controller_if.slave (see interface header)
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in ESPERA before a timeout (2..65535),
//                   only meaningful with SEQUENCE_ROUND_CONTROLLER_TIMEOUT_EN
// Build option:
//   SEQUENCE_ROUND_CONTROLLER_TIMEOUT_EN  enables the ESPERA timeout counter
//   and the FIM_TIMEOUT exit; otherwise ESPERA waits indefinitely.
//
// state       | meaning
// ------------+------------------------------------------------
// INICIAL     | idle, waiting for iniciar
// PREPARACAO  | clear position counter and player register
// ESPERA      | waiting for a player press
// REGISTRA    | load the player's play
// COMPARA     | check play against memory, decide next step
// PROXIMO     | advance position counter
// FIM_ACERTO  | round over, every position correct
// FIM_ERRO    | round over, mismatch
// FIM_TIMEOUT | round over, player took too long
module sequence_round_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                        clock,
  input  logic                        reset,
  sequence_round_controller_if.slave  bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  // The state code doubles as the debug display value.
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } state_t;

  state_t state;
  logic   jogada_d;
  logic   ev;

  assign ev = bus.jogada & ~jogada_d;

`ifdef SEQUENCE_ROUND_CONTROLLER_TIMEOUT_EN
  logic [15:0] t_cnt;
  logic        t_expired;

  assign t_expired = (t_cnt == 16'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INICIAL;
      jogada_d <= 1'b0;
`ifdef SEQUENCE_ROUND_CONTROLLER_TIMEOUT_EN
      t_cnt    <= '0;
`endif
    end else begin
      jogada_d <= bus.jogada;
`ifdef SEQUENCE_ROUND_CONTROLLER_TIMEOUT_EN
      // Held at zero outside ESPERA, so every entry starts a fresh count.
      t_cnt    <= (state == ESPERA) ? t_cnt + 16'd1 : '0;
`endif
      case (state)
        INICIAL:    if (bus.iniciar) state <= PREPARACAO;
        PREPARACAO: state <= ESPERA;
        ESPERA: begin
          // A press in the expiry cycle still counts as a play.
          if (ev) state <= REGISTRA;
`ifdef SEQUENCE_ROUND_CONTROLLER_TIMEOUT_EN
          else if (t_expired) state <= FIM_TIMEOUT;
`endif
        end
        REGISTRA:   state <= COMPARA;
        COMPARA: begin
          if (!bus.igual)     state <= FIM_ERRO;
          else if (bus.fim_c) state <= FIM_ACERTO;
          else                state <= PROXIMO;
        end
        PROXIMO:    state <= ESPERA;
        FIM_ACERTO,
        FIM_ERRO,
        FIM_TIMEOUT: if (bus.iniciar) state <= PREPARACAO;
        default:    state <= INICIAL;
      endcase
    end
  end

  // Moore outputs, decoded from the state register alone.
  assign bus.db_estado  = state;
  assign bus.zera_c     = (state != PREPARACAO);
  assign bus.zera_r     = (state == PREPARACAO);
  assign bus.registra_r = (state == REGISTRA);
  assign bus.conta_c    = (state == PROXIMO);
  assign bus.pronto     = (state == FIM_ACERTO) || (state == FIM_ERRO) ||
                          (state == FIM_TIMEOUT);
  assign bus.acertou    = (state == FIM_ACERTO);
  assign bus.errou      = (state == FIM_ERRO) || (state == FIM_TIMEOUT);
`ifdef SEQUENCE_ROUND_CONTROLLER_TIMEOUT_EN
  assign bus.timeout    = (state == FIM_TIMEOUT);
`else
  assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_sequence_round_controller.sv
module tb_sequence_round_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sequence_round_controller_if bus_if ();

  sequence_round_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  // Mod-6 74163-style position counter model: sync clear, enable, rco at 5.
  logic [3:0] q = 4'd0;
  always @(posedge clock) begin
    if (!bus_if.zera_c)      q <= 4'd0;
    else if (bus_if.conta_c) q <= (q == 4'd5) ? 4'd0 : q + 4'd1;
  end
  assign bus_if.fim_c = (q == 4'd5);

  // Cycle counters of observed activity.
  int n_conta = 0;
  int n_reg   = 0;
  int n_cmp   = 0;
  always @(posedge clock) begin
    if (bus_if.conta_c === 1'b1)      n_conta++;
    if (bus_if.db_estado === 4'h4)    n_reg++;
    if (bus_if.db_estado === 4'h5)    n_cmp++;
  end

  // {db_estado, zera_c, conta_c, zera_r, registra_r, pronto, acertou, errou, timeout}
  localparam logic [11:0] S_INI  = 12'h080;
  localparam logic [11:0] S_PREP = 12'h120;
  localparam logic [11:0] S_ESP  = 12'h280;
  localparam logic [11:0] S_REG  = 12'h490;
  localparam logic [11:0] S_CMP  = 12'h580;
  localparam logic [11:0] S_PROX = 12'h6C0;
  localparam logic [11:0] S_ACE  = 12'hA8C;
  localparam logic [11:0] S_ERR  = 12'hE8A;
  localparam logic [11:0] S_TMO  = 12'hD8B;

  typedef struct {
    logic        iniciar;
    logic        jogada;
    logic        igual;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[17];
  int tests = 0;
  int fails = 0;

  function automatic logic [11:0] outs();
    return {bus_if.db_estado, bus_if.zera_c, bus_if.conta_c, bus_if.zera_r,
            bus_if.registra_r, bus_if.pronto, bus_if.acertou, bus_if.errou,
            bus_if.timeout};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic ini, input logic jog, input logic ig);
    bus_if.iniciar = ini;
    bus_if.jogada  = jog;
    bus_if.igual   = ig;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic start_round();
    bus_if.iniciar = 1'b1;
    step();
    check("start_prep", 32'(outs()), 32'(S_PREP));
    bus_if.iniciar = 1'b0;
    step();
    check("start_espera", 32'(outs()), 32'(S_ESP));
  endtask

  // One press: leaves the FSM in the state following COMPARA.
  task automatic play(input logic ig);
    bus_if.jogada = 1'b1;
    step();
    check("play_registra", 32'(outs()), 32'(S_REG));
    bus_if.jogada = 1'b0;
    bus_if.igual  = ig;
    step();
    check("play_compara", 32'(outs()), 32'(S_CMP));
    step();
  endtask

  initial begin
    int c0, r0, k0;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, S_INI};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, S_PREP};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, S_ESP};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, S_ESP};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, S_REG};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, S_CMP};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, S_PROX};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, S_ESP};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, S_REG};   // iniciar ignored in ESPERA
    vecs[9]  = '{1'b0, 1'b0, 1'b0, S_CMP};
    vecs[10] = '{1'b0, 1'b0, 1'b0, S_ERR};
    vecs[11] = '{1'b0, 1'b1, 1'b0, S_ERR};   // press outside ESPERA discarded
    vecs[12] = '{1'b1, 1'b1, 1'b0, S_PREP};
    vecs[13] = '{1'b0, 1'b1, 1'b0, S_ESP};
    vecs[14] = '{1'b0, 1'b1, 1'b0, S_ESP};   // still held: no new event
    vecs[15] = '{1'b0, 1'b0, 1'b0, S_ESP};
    vecs[16] = '{1'b0, 1'b1, 1'b1, S_REG};

    reset_dut();
    check("reset_state", 32'(outs()), 32'(S_INI));

    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].iniciar, vecs[i].jogada, vecs[i].igual);
      step();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Full correct round: six plays, five counter steps.
    reset_dut();
    start_round();
    check("round_q0", 32'(q), 32'd0);
    c0 = n_conta;
    for (int i = 0; i < 6; i++) begin
      play(1'b1);
      if (i < 5) begin
        check($sformatf("round_prox%0d", i), 32'(outs()), 32'(S_PROX));
        step();
      end
    end
    check("round_acerto", 32'(outs()), 32'(S_ACE));
    check("round_conta_pulses", 32'(n_conta - c0), 32'd5);
    check("round_q5", 32'(q), 32'd5);
    step();
    check("round_hold", 32'(outs()), 32'(S_ACE));

    // Mismatch on the third compare.
    start_round();
    play(1'b1); step();
    play(1'b1); step();
    play(1'b0);
    check("mis_erro", 32'(outs()), 32'(S_ERR));
    check("mis_q2", 32'(q), 32'd2);
    bus_if.iniciar = 1'b1;
    step();
    check("mis_restart_prep", 32'(outs()), 32'(S_PREP));
    bus_if.iniciar = 1'b0;
    step();
    check("mis_restart_q0", 32'(q), 32'd0);
    check("mis_restart_espera", 32'(outs()), 32'(S_ESP));

    // jogada held high for 20 cycles in ESPERA.
    c0 = n_conta; r0 = n_reg; k0 = n_cmp;
    bus_if.igual  = 1'b1;
    bus_if.jogada = 1'b1;
    repeat (20) step();
    bus_if.jogada = 1'b0;
    step();
    step();
    check("held_registra", 32'(n_reg - r0), 32'd1);
    check("held_compara", 32'(n_cmp - k0), 32'd1);
    check("held_conta", 32'(n_conta - c0), 32'd1);
    check("held_espera", 32'(outs()), 32'(S_ESP));
    check("held_q1", 32'(q), 32'd1);

    // Reset asserted while in COMPARA with igual=0.
    bus_if.jogada = 1'b1;
    step();
    bus_if.jogada = 1'b0;
    bus_if.igual  = 1'b0;
    step();
    check("rst_in_compara", 32'(outs()), 32'(S_CMP));
    reset = 1'b1;
    step();
    check("rst_to_inicial", 32'(outs()), 32'(S_INI));
    reset = 1'b0;
    step();
    check("rst_stays_inicial", 32'(outs()), 32'(S_INI));

`ifdef SEQUENCE_ROUND_CONTROLLER_TIMEOUT_EN
    // Timeout after 8 cycles in ESPERA.
    reset_dut();
    start_round();
    repeat (7) step();
    check("tmo_before", 32'(outs()), 32'(S_ESP));
    step();
    check("tmo_fim", 32'(outs()), 32'(S_TMO));
    step();
    check("tmo_hold", 32'(outs()), 32'(S_TMO));
    // A press on the 8th cycle beats the timeout.
    start_round();
    repeat (7) step();
    bus_if.jogada = 1'b1;
    step();
    check("tmo_jogada_wins", 32'(outs()), 32'(S_REG));
    bus_if.jogada = 1'b0;
`else
    reset_dut();
    start_round();
    repeat (60) step();
    check("no_timeout", 32'(outs()), 32'(S_ESP));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
